// File: rtl/vga_sprite_timing_gen.sv
// VGA raster timing generator with a movable single-colour sprite box.
// Sprite position requests are double-buffered and applied during vertical blanking.
module vga_sprite_timing_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int COLOR_W = 4,
    parameter int BOX_W = 8,
    parameter int BOX_H = 8,
    parameter int INIT_X = 560,
    parameter int INIT_Y = 10,
    parameter logic [COLOR_W-1:0] FG_R = '1,
    parameter logic [COLOR_W-1:0] FG_G = '1,
    parameter logic [COLOR_W-1:0] FG_B = '1,
    parameter logic [COLOR_W-1:0] BG_R = '0,
    parameter logic [COLOR_W-1:0] BG_G = '0,
    parameter logic [COLOR_W-1:0] BG_B = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               pos_valid,
    output logic               pos_ready,
    output logic               vga_h_sync,
    output logic               vga_v_sync,
    output logic               inDisplayArea,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] BOX_XE = 11'(BOX_W - 1);
    localparam logic [10:0] BOX_YE = 11'(BOX_H - 1);

    logic [DIV_W-1:0] r_div;
    logic [10:0]      r_cx;
    logic [10:0]      r_cy;
    logic [9:0]       r_box_x;
    logic [9:0]       r_box_y;
    logic [9:0]       r_sh_x;
    logic [9:0]       r_sh_y;
    logic             r_pending;

    logic w_tick;
    logic w_in_area;
    logic w_hs_on;
    logic w_vs_on;
    logic w_hit;
    logic w_xfer;
    logic w_apply;
    logic [10:0] w_bx;
    logic [10:0] w_by;

    assign w_tick = (r_div == DIV_LAST);
    assign w_in_area = (r_cx < H_ACT) && (r_cy < V_ACT);
    assign w_hs_on = (r_cx >= HS_BEG) && (r_cx < HS_END);
    assign w_vs_on = (r_cy >= VS_BEG) && (r_cy < VS_END);
    // 11-bit compare so a box near column/line 1023 never wraps to 0
    assign w_bx = {1'b0, r_box_x};
    assign w_by = {1'b0, r_box_y};
    assign w_hit = (r_cx >= w_bx) && (r_cx <= w_bx + BOX_XE) &&
                   (r_cy >= w_by) && (r_cy <= w_by + BOX_YE);
    assign pos_ready = !r_pending;
    assign w_xfer = pos_valid && !r_pending;
    assign w_apply = w_tick && r_pending && (r_cx == '0) && (r_cy == V_ACT);

    // Pixel tick divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Raster position counters, advanced once per pixel tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (w_tick) begin
            if (r_cx == H_LAST) begin
                r_cx <= '0;
                r_cy <= (r_cy == V_LAST) ? '0 : r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    // Request shadow and apply-at-vblank so the box never tears mid-frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
            r_sh_x <= '0;
            r_sh_y <= '0;
            r_box_x <= 10'(INIT_X);
            r_box_y <= 10'(INIT_Y);
        end else if (w_apply) begin
            r_pending <= 1'b0;
            r_box_x <= r_sh_x;
            r_box_y <= r_sh_y;
        end else if (w_xfer) begin
            r_pending <= 1'b1;
            r_sh_x <= pos_x;
            r_sh_y <= pos_y;
        end
    end

    // Registered video outputs from the pre-increment raster position
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_h_sync <= ~SYNC_POL;
            vga_v_sync <= ~SYNC_POL;
            inDisplayArea <= 1'b0;
            r <= '0;
            g <= '0;
            b <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_tick && (r_cx == '0) && (r_cy == '0);
            if (w_tick) begin
                vga_h_sync <= w_hs_on ? SYNC_POL : ~SYNC_POL;
                vga_v_sync <= w_vs_on ? SYNC_POL : ~SYNC_POL;
                inDisplayArea <= w_in_area;
                if (w_in_area) begin
                    r <= w_hit ? FG_R : BG_R;
                    g <= w_hit ? FG_G : BG_G;
                    b <= w_hit ? FG_B : BG_B;
                end else begin
                    r <= '0;
                    g <= '0;
                    b <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sprite_timing_gen.sv
// Bench for vga_sprite_timing_gen: small raster with divided clock, plus
// a CLK_DIV=1 instance for frame length and mid-line reset behaviour.
module tb_vga_sprite_timing_gen;

    localparam int HT1 = 28;
    localparam int VT1 = 21;
    localparam int HT2 = 14;
    localparam int VT2 = 7;

    typedef struct {
        int ph;
        int x;
        int y;
        logic de;
        logic hs;
        logic vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst2;
    logic [9:0] px1, py1, px2, py2;
    logic pv1, pv2;
    logic rdy1, hs1, vs1, de1, fs1;
    logic rdy2, hs2, vs2, de2, fs2;
    logic [3:0] r1, g1, b1, r2, g2, b2;

    vga_sprite_timing_gen #(
        .CLK_DIV(2),
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(16), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .COLOR_W(4),
        .BOX_W(4), .BOX_H(4), .INIT_X(12), .INIT_Y(2),
        .FG_R(4'hF), .FG_G(4'hE), .FG_B(4'hD),
        .BG_R(4'h1), .BG_G(4'h2), .BG_B(4'h3)
    ) dut1 (
        .clk(clk), .rst(rst1),
        .pos_x(px1), .pos_y(py1), .pos_valid(pv1), .pos_ready(rdy1),
        .vga_h_sync(hs1), .vga_v_sync(vs1), .inDisplayArea(de1),
        .r(r1), .g(g1), .b(b1), .frame_start(fs1)
    );

    vga_sprite_timing_gen #(
        .CLK_DIV(1),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .BOX_W(2), .BOX_H(2), .INIT_X(1), .INIT_Y(1)
    ) dut2 (
        .clk(clk), .rst(rst2),
        .pos_x(px2), .pos_y(py2), .pos_valid(pv2), .pos_ready(rdy2),
        .vga_h_sync(hs2), .vga_v_sync(vs2), .inDisplayArea(de2),
        .r(r2), .g(g2), .b(b2), .frame_start(fs2)
    );

    int n_chk = 0;
    int n_err = 0;
    int edges = 0;
    int cur_f = -1, cur_x = -1, cur_y = -1;
    int fs_cnt = 0, fs_bad = 0;
    logic cap_de [VT1][HT1];
    logic cap_hs [VT1][HT1];
    logic cap_vs [VT1][HT1];
    logic [3:0] cap_r [VT1][HT1];
    logic [3:0] cap_g [VT1][HT1];
    logic [3:0] cap_b [VT1][HT1];
    vec_t tab[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // kind: 0 = blank, 1 = background, 2 = sprite
    task automatic add(input int ph, input int x, input int y,
                       input int kind, input logic hs, input logic vs);
        vec_t v;
        v.ph = ph; v.x = x; v.y = y; v.hs = hs; v.vs = vs;
        v.de = (kind != 0);
        v.r = (kind == 2) ? 4'hF : (kind == 1) ? 4'h1 : 4'h0;
        v.g = (kind == 2) ? 4'hE : (kind == 1) ? 4'h2 : 4'h0;
        v.b = (kind == 2) ? 4'hD : (kind == 1) ? 4'h3 : 4'h0;
        tab.push_back(v);
    endtask

    task automatic step1();
        int p;
        @(posedge clk);
        #1;
        edges++;
        if (edges % 2 == 0) begin
            p = edges / 2 - 1;
            cur_x = p % HT1;
            cur_y = (p / HT1) % VT1;
            cur_f = p / (HT1 * VT1);
            cap_de[cur_y][cur_x] = de1;
            cap_hs[cur_y][cur_x] = hs1;
            cap_vs[cur_y][cur_x] = vs1;
            cap_r[cur_y][cur_x] = r1;
            cap_g[cur_y][cur_x] = g1;
            cap_b[cur_y][cur_x] = b1;
            if (fs1) begin
                if (cur_x == 0 && cur_y == 0) fs_cnt++;
                else fs_bad++;
            end
        end else if (fs1) begin
            fs_bad++;
        end
    endtask

    task automatic run_until(input int f, input int y, input int x);
        int g = 0;
        while (!(cur_f == f && cur_y == y && cur_x == x) && g < 6000) begin
            step1();
            g++;
        end
        if (g >= 6000) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout reaching f%0d (%0d,%0d)", f, x, y);
        end
    endtask

    task automatic check_tab(input int ph);
        foreach (tab[i]) begin
            if (tab[i].ph == ph) begin
                chk($sformatf("px ph%0d (%0d,%0d)", ph, tab[i].x, tab[i].y),
                    32'({cap_de[tab[i].y][tab[i].x],
                         cap_hs[tab[i].y][tab[i].x],
                         cap_vs[tab[i].y][tab[i].x],
                         cap_r[tab[i].y][tab[i].x],
                         cap_g[tab[i].y][tab[i].x],
                         cap_b[tab[i].y][tab[i].x]}),
                    32'({tab[i].de, tab[i].hs, tab[i].vs,
                         tab[i].r, tab[i].g, tab[i].b}));
            end
        end
    endtask

    initial begin
        int hs_low, hs_first, vs_low, vs_first, n, e2, fs2_cnt;
        int hs2_low, vs2_low;
        logic l11, l22, l52, l31;

        add(0, 0, 0, 1, 1, 1);   add(0, 12, 2, 2, 1, 1);
        add(0, 15, 5, 2, 1, 1);  add(0, 11, 2, 1, 1, 1);
        add(0, 16, 2, 1, 1, 1);  add(0, 12, 6, 1, 1, 1);
        add(0, 12, 1, 1, 1, 1);  add(0, 19, 15, 1, 1, 1);
        add(0, 20, 0, 0, 1, 1);  add(0, 21, 0, 0, 1, 1);
        add(0, 22, 0, 0, 0, 1);  add(0, 24, 3, 0, 0, 1);
        add(0, 25, 3, 0, 1, 1);  add(0, 27, 20, 0, 1, 1);
        add(0, 0, 16, 0, 1, 1);  add(0, 0, 17, 0, 1, 0);
        add(0, 23, 18, 0, 0, 0); add(0, 5, 19, 0, 1, 1);
        add(1, 12, 2, 2, 1, 1);  add(1, 3, 5, 1, 1, 1);
        add(1, 15, 5, 2, 1, 1);
        add(2, 3, 5, 2, 1, 1);   add(2, 6, 8, 2, 1, 1);
        add(2, 7, 5, 1, 1, 1);   add(2, 3, 9, 1, 1, 1);
        add(2, 2, 5, 1, 1, 1);   add(2, 12, 2, 1, 1, 1);
        add(2, 9, 9, 1, 1, 1);
        add(3, 18, 14, 2, 1, 1); add(3, 19, 15, 2, 1, 1);
        add(3, 17, 14, 1, 1, 1); add(3, 18, 13, 1, 1, 1);
        add(3, 0, 14, 1, 1, 1);  add(3, 0, 0, 1, 1, 1);
        add(3, 1, 15, 1, 1, 1);  add(3, 18, 16, 0, 1, 1);
        add(4, 0, 0, 1, 1, 1);   add(4, 1, 1, 1, 1, 1);
        add(4, 0, 1, 1, 1, 1);   add(4, 19, 15, 1, 1, 1);

        rst1 = 1'b1; rst2 = 1'b1;
        px1 = '0; py1 = '0; pv1 = 1'b0;
        px2 = '0; py2 = '0; pv2 = 1'b0;
        #2;
        rst1 = 1'b0; rst2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst1 outs", 32'({hs1, vs1, de1, r1, g1, b1, fs1, rdy1}),
            32'({1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1}));
        chk("rst2 outs", 32'({hs2, vs2, de2, r2, g2, b2, fs2, rdy2}),
            32'({1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1}));

        @(negedge clk);
        rst1 = 1'b1;
        step1();
        chk("no tick on first clk", 32'({fs1, de1, hs1}), 32'({1'b0, 1'b0, 1'b1}));
        step1();
        chk("first tick frame_start", 32'(fs1), 32'(1));

        run_until(0, VT1 - 1, HT1 - 1);
        check_tab(0);
        hs_low = 0; hs_first = -1; vs_low = 0; vs_first = -1;
        for (int x = 0; x < HT1; x++) begin
            if (!cap_hs[0][x]) begin
                hs_low++;
                if (hs_first < 0) hs_first = x;
            end
        end
        for (int y = 0; y < VT1; y++) begin
            if (!cap_vs[y][0]) begin
                vs_low++;
                if (vs_first < 0) vs_first = y;
            end
        end
        chk("hsync width", 32'(hs_low), 32'(3));
        chk("hsync start", 32'(hs_first), 32'(22));
        chk("vsync lines", 32'(vs_low), 32'(2));
        chk("vsync start", 32'(vs_first), 32'(17));

        run_until(1, 5, 0);
        chk("ready idle", 32'(rdy1), 32'(1));
        px1 = 10'd3; py1 = 10'd5; pv1 = 1'b1;
        step1();
        chk("ready drops", 32'(rdy1), 32'(0));
        px1 = 10'd7; py1 = 10'd7;
        repeat (4) step1();
        pv1 = 1'b0;
        run_until(1, 15, HT1 - 1);
        chk("ready held pending", 32'(rdy1), 32'(0));
        run_until(1, 16, 0);
        chk("ready after apply", 32'(rdy1), 32'(1));
        run_until(1, VT1 - 1, HT1 - 1);
        check_tab(1);

        run_until(2, 2, 0);
        px1 = 10'd18; py1 = 10'd14; pv1 = 1'b1;
        step1();
        pv1 = 1'b0;
        run_until(2, VT1 - 1, HT1 - 1);
        check_tab(2);

        run_until(3, 2, 0);
        px1 = 10'd1022; py1 = 10'd1022; pv1 = 1'b1;
        step1();
        pv1 = 1'b0;
        run_until(3, VT1 - 1, HT1 - 1);
        check_tab(3);
        run_until(4, VT1 - 1, HT1 - 1);
        check_tab(4);
        chk("frame_start count", 32'(fs_cnt), 32'(5));
        chk("frame_start stray", 32'(fs_bad), 32'(0));

        @(negedge clk);
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        chk("div1 first tick fs", 32'({fs2, de2}), 32'({1'b1, 1'b1}));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!fs2 && n < 200);
        chk("div1 frame clk", 32'(n), 32'(HT2 * VT2));
        px2 = 10'd5; py2 = 10'd2; pv2 = 1'b1;
        @(posedge clk);
        #1;
        pv2 = 1'b0;
        chk("div1 ready drops", 32'(rdy2), 32'(0));
        repeat (4) @(posedge clk);
        #1;
        chk("div1 pre-reset de", 32'(de2), 32'(1));
        #2;
        rst2 = 1'b0;
        #1;
        chk("mid-line reset outs", 32'({hs2, vs2, de2, r2, g2, b2, fs2, rdy2}),
            32'({1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1}));
        @(negedge clk);
        rst2 = 1'b1;
        e2 = 0; fs2_cnt = 0; hs2_low = 0; vs2_low = 0;
        l11 = 1'b0; l22 = 1'b0; l52 = 1'b1; l31 = 1'b1;
        for (int k = 0; k < 2 * HT2 * VT2; k++) begin
            int p, x, y;
            @(posedge clk);
            #1;
            e2++;
            p = e2 - 1;
            x = p % HT2;
            y = (p / HT2) % VT2;
            if (fs2) fs2_cnt++;
            if (e2 == 1) chk("post-reset fs", 32'(fs2), 32'(1));
            if (p / (HT2 * VT2) == 1) begin
                if (!hs2) hs2_low++;
                if (!vs2) vs2_low++;
                if (x == 1 && y == 1) l11 = (r2 == 4'hF);
                if (x == 2 && y == 2) l22 = (r2 == 4'hF);
                if (x == 5 && y == 2) l52 = (r2 == 4'hF);
                if (x == 3 && y == 1) l31 = (r2 == 4'hF);
            end
        end
        chk("div1 fs count", 32'(fs2_cnt), 32'(2));
        chk("div1 hsync ticks", 32'(hs2_low), 32'(2 * VT2));
        chk("div1 vsync ticks", 32'(vs2_low), 32'(HT2));
        chk("div1 sprite kept", 32'({l11, l22, l52, l31}),
            32'({1'b1, 1'b1, 1'b0, 1'b0}));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_sprite_timing_gen.md
VGA_SPRITE_TIMING_GEN -- requirements
Module: vga_sprite_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 2: system clocks per pixel tick (>=1).
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels; H_TOTAL = sum.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines; V_TOTAL = sum.
REQ-004 Parameter SYNC_POL, default 0: asserted sync level (0 = active-low).
REQ-005 Parameter COLOR_W, default 4: bits per colour channel.
REQ-006 Parameters BOX_W/BOX_H, defaults 8/8: sprite size in pixels.
REQ-007 Parameters INIT_X/INIT_Y, defaults 560/10: sprite position after reset.
REQ-008 Parameters FG_R/FG_G/FG_B, default all-ones; BG_R/BG_G/BG_B, default 0: sprite and background colours.
REQ-009 clk  in  1  system clock; single clock domain.
REQ-010 rst  in  1  asynchronous, active-low reset.
REQ-011 pos_x  in  10  requested sprite left column.
REQ-012 pos_y  in  10  requested sprite top line.
REQ-013 pos_valid  in  1  position request valid.
REQ-014 pos_ready  out  1  block can accept a request.
REQ-015 vga_h_sync  out  1  horizontal sync.
REQ-016 vga_v_sync  out  1  vertical sync.
REQ-017 inDisplayArea  out  1  current pixel is in the active area.
REQ-018 r, g, b  out  COLOR_W each  pixel colour.
REQ-019 frame_start  out  1  one-clock pulse at the start of each frame.

Function
REQ-020 Divider counts 0..CLK_DIV-1; pixel tick asserted for one clk when divider = CLK_DIV-1 (every clk when CLK_DIV=1).
REQ-021 cx advances on tick only; wraps H_TOTAL-1 -> 0; range 0..H_TOTAL-1, no extra state.
REQ-022 cy advances on the tick where cx wraps; wraps V_TOTAL-1 -> 0.
REQ-023 All video outputs registered on tick, computed from pre-increment cx/cy: one-tick latency, mutually aligned.
REQ-024 vga_h_sync = SYNC_POL for H_ACTIVE+H_FP <= cx < H_ACTIVE+H_FP+H_SYNC (exactly H_SYNC ticks); ~SYNC_POL otherwise.
REQ-025 vga_v_sync = SYNC_POL for V_ACTIVE+V_FP <= cy < V_ACTIVE+V_FP+V_SYNC (exactly V_SYNC lines); ~SYNC_POL otherwise.
REQ-026 inDisplayArea = (cx < H_ACTIVE) && (cy < V_ACTIVE).
REQ-027 Sprite hit: box_x <= cx <= box_x+BOX_W-1 and box_y <= cy <= box_y+BOX_H-1, compared at 11 bits (no wrap); clipped to active area.
REQ-028 r/g/b = FG on hit in active area; BG elsewhere in active area; 0 outside active area.
REQ-029 frame_start pulses one clk on the tick registering cx=0, cy=0.
REQ-030 Handshake: transfer when pos_valid && pos_ready; pos_x/pos_y captured to shadow; pending set; pos_ready = !pending.
REQ-031 Apply: on the tick where cx=0 and cy=V_ACTIVE, a pending shadow copies to box_x/box_y and pending clears; pos_ready high on the next clk.
REQ-032 box_x/box_y change only at apply; the sprite never tears within a frame.
REQ-033 pos_valid while pos_ready=0 is ignored; the shadow keeps the first request.
REQ-034 Request accepted on the apply clk itself: impossible (ready=0); applied in the following frame's blanking.
REQ-035 Positions beyond the active area are legal; the sprite is clipped or invisible, with no wrap to column/line 0.

Reset
REQ-036 rst low asynchronously: divider, cx, cy = 0; vga_h_sync, vga_v_sync = ~SYNC_POL; inDisplayArea, r, g, b, frame_start = 0; pending = 0; pos_ready = 1; box = INIT_X, INIT_Y.
REQ-037 Reset mid-frame discards a pending request; after release, the first tick registers cx=0, cy=0 and pulses frame_start.

Verification
REQ-038 Defaults, free-run: line = 1600 clk; frame = 525 lines; vga_h_sync low for exactly 96 ticks from registered cx=656; vga_v_sync low for lines 490-491.
REQ-039 Defaults, no request: r=g=b=4'hF exactly at pixels x 560-567, y 10-17; 0 at (559,10), (568,10), (560,18).
REQ-040 pos (100,200) valid at line 50 -> pos_ready=0 next clk; sprite still at 560,10 through line 479; applied at line 480 col 0 tick; next frame shows it at x 100-107, y 200-207; pos_ready=1 again.
REQ-041 Second request (300,300) while pending -> ignored; (100,200) applied.
REQ-042 pos (636,478) -> only pixels x 636-639, y 478-479 lit; columns 0-3 and lines 0-5 stay dark.
REQ-043 CLK_DIV=1, timing 8/2/2/2 x 4/1/1/1 -> line 14 clk, frame 7 lines; assert rst at cx=5 -> all outputs at reset values immediately; pending request lost.
